// File: rtl/sseg_scan_driver.sv
// Four-digit common-anode 7-segment scan driver.
// A 16-bit hex value is captured on a load strobe into a pending buffer and
// copied to the display buffer only at the end of a full scan frame, so a
// frame never mixes digits from two different values.
module sseg_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 17
) (
    input  logic        CLOCK,
    input  logic        RST_N,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic [7:0]  sseg,
    output logic [3:0]  DISP_EN,
    output logic        pending,
    output logic        frame_tick
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    // Hex nibble to active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // A digit is a leading zero when it and every digit to its left are zero;
    // the rightmost digit always stays lit so a zero value still shows "0".
    function automatic logic digit_blank(input logic [15:0] val,
                                         input logic [1:0]  idx,
                                         input logic        en);
        logic [15:0] upper;
        upper = val >> {idx, 2'b00};
        return en && (idx != 2'd0) && (upper == 16'd0);
    endfunction

    logic [CNT_W-1:0] cnt_p0;
    logic [1:0]       idx_p0;
    logic             boundary_p0;

    logic [15:0] disp_val;
    logic [3:0]  disp_dp;
    logic [15:0] pend_val;
    logic [3:0]  pend_dp;

    logic [15:0] nib_src_p0;
    logic [3:0]  nib_p0;
    logic        blank_p0;
    logic [7:0]  sseg_nxt_p0;
    logic [3:0]  en_nxt_p0;

    assign boundary_p0 = (cnt_p0 == CNT_LAST) && (idx_p0 == 2'd3);

    // Dwell counter and digit index; free-running, wraps every frame.
    always_ff @(posedge CLOCK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_p0 <= '0;
            idx_p0 <= 2'd0;
        end else if (cnt_p0 == CNT_LAST) begin
            cnt_p0 <= '0;
            idx_p0 <= idx_p0 + 2'd1;
        end else begin
            cnt_p0 <= cnt_p0 + CNT_W'(1);
        end
    end

    // Double buffer: loads land in pend_*, the frame boundary promotes them.
    // A load on the boundary cycle promotes the older pending value and
    // leaves the new one waiting for the following boundary.
    always_ff @(posedge CLOCK or negedge RST_N) begin
        if (!RST_N) begin
            disp_val <= 16'd0;
            disp_dp  <= 4'd0;
            pend_val <= 16'd0;
            pend_dp  <= 4'd0;
            pending  <= 1'b0;
        end else begin
            if (boundary_p0 && pending) begin
                disp_val <= pend_val;
                disp_dp  <= pend_dp;
            end
            if (load) begin
                pend_val <= data_in;
                pend_dp  <= dp_in;
                pending  <= 1'b1;
            end else if (boundary_p0) begin
                pending  <= 1'b0;
            end
        end
    end

    // Segment pattern and anode select for the digit currently addressed.
    always_comb begin
        nib_src_p0 = disp_val >> {idx_p0, 2'b00};
        nib_p0     = nib_src_p0[3:0];
        blank_p0   = digit_blank(disp_val, idx_p0, blank_lz);
        if (blank_p0) begin
            sseg_nxt_p0 = 8'hFF;
            en_nxt_p0   = 4'b1111;
        end else begin
            sseg_nxt_p0 = {~disp_dp[idx_p0], seg_decode(nib_p0)};
            en_nxt_p0   = ~(4'b0001 << idx_p0);
        end
    end

    // ---- stage p0 -> p1: registered pin drivers ----
    // Register the pins so the board sees glitch-free segment/anode lines.
    always_ff @(posedge CLOCK or negedge RST_N) begin
        if (!RST_N) begin
            sseg       <= 8'hFF;
            DISP_EN    <= 4'b1111;
            frame_tick <= 1'b0;
        end else begin
            sseg       <= sseg_nxt_p0;
            DISP_EN    <= en_nxt_p0;
            frame_tick <= boundary_p0;
        end
    end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for sseg_scan_driver with a four-cycle dwell. A frame-level model
// tracks the shown value, the waiting value and the elapsed cycle count and
// predicts every output after every clock edge.
module tb_sseg_scan_driver;

    localparam int RDIV = 4;

    logic        CLOCK = 1'b0;
    logic        RST_N = 1'b0;
    logic [15:0] data_in = 16'd0;
    logic [3:0]  dp_in = 4'd0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [7:0]  sseg;
    logic [3:0]  DISP_EN;
    logic        pending;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    sseg_scan_driver #(.REFRESH_DIV(RDIV), .CNT_W(3)) dut (
        .CLOCK(CLOCK), .RST_N(RST_N), .data_in(data_in), .dp_in(dp_in),
        .load(load), .blank_lz(blank_lz), .sseg(sseg), .DISP_EN(DISP_EN),
        .pending(pending), .frame_tick(frame_tick)
    );

    always #5 CLOCK = ~CLOCK;

    // Reference model state
    logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int          t;
    logic [15:0] shown;
    logic [3:0]  shown_dp;
    logic [15:0] q_val;
    logic [3:0]  q_dp;
    logic        q_valid;

    task automatic model_reset();
        t = 0; shown = 16'd0; shown_dp = 4'd0;
        q_val = 16'd0; q_dp = 4'd0; q_valid = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, predict, compare on the falling edge.
    task automatic step(input logic ld, input logic [15:0] din, input logic [3:0] dp,
                        input logic blz);
        int          dig;
        logic [15:0] upper;
        logic        bnd;
        logic [7:0]  es;
        logic [3:0]  ee;
        load = ld; data_in = din; dp_in = dp; blank_lz = blz;
        @(posedge CLOCK);
        dig   = (t / RDIV) % 4;
        upper = shown >> (4 * dig);
        bnd   = (t % (4 * RDIV)) == (4 * RDIV - 1);
        if (blz && dig != 0 && upper == 16'd0) begin
            es = 8'hFF;
            ee = 4'hF;
        end else begin
            es = {~shown_dp[dig], seg_tab[upper[3:0]]};
            ee = ~(4'(1 << dig));
        end
        if (bnd && q_valid) begin
            shown    = q_val;
            shown_dp = q_dp;
        end
        if (ld) begin
            q_val = din; q_dp = dp; q_valid = 1'b1;
        end else if (bnd) begin
            q_valid = 1'b0;
        end
        t++;
        @(negedge CLOCK);
        chk("sseg", 16'(sseg), 16'(es));
        chk("disp_en", 16'(DISP_EN), 16'(ee));
        chk("pending", 16'(pending), 16'(q_valid));
        chk("frame_tick", 16'(frame_tick), 16'(bnd));
        load = 1'b0;
    endtask

    task automatic run_to_tick(input logic blz);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step(1'b0, 16'd0, 4'd0, blz);
            if (frame_tick === 1'b1) seen = 1'b1;
        end
        chk("tick_seen", 16'(seen), 16'd1);
    endtask

    // Must be called at a frame start; es/ee pack digit0 in the low bits.
    task automatic frame_expect(input logic blz, input logic [31:0] es, input logic [15:0] ee);
        for (int k = 0; k < 4 * RDIV; k++) begin
            step(1'b0, 16'd0, 4'd0, blz);
            if (k % RDIV == 0) begin
                chk("frame_sseg", 16'(sseg), 16'(es[8*(k/RDIV) +: 8]));
                chk("frame_en", 16'(DISP_EN), 16'(ee[4*(k/RDIV) +: 4]));
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge CLOCK);
        @(negedge CLOCK);
        chk("rst_sseg", 16'(sseg), 16'h00FF);
        chk("rst_en", 16'(DISP_EN), 16'h000F);
        chk("rst_pending", 16'(pending), 16'd0);
        chk("rst_tick", 16'(frame_tick), 16'd0);
        RST_N = 1'b1;

        // Idle scan of zero
        frame_expect(1'b0, 32'hC0C0C0C0, 16'h7BDE);
        frame_expect(1'b0, 32'hC0C0C0C0, 16'h7BDE);

        // Plain load with a decimal point
        step(1'b1, 16'h12AF, 4'b0100, 1'b0);
        run_to_tick(1'b0);
        chk("pending_after_tick", 16'(pending), 16'd0);
        frame_expect(1'b0, 32'hF924888E, 16'h7BDE);

        // Leading-zero blanking on and off
        step(1'b1, 16'h0005, 4'd0, 1'b1);
        run_to_tick(1'b1);
        frame_expect(1'b1, 32'hFFFFFF92, 16'hFFFE);
        frame_expect(1'b0, 32'hC0C0C092, 16'h7BDE);

        // Two loads before one boundary: last wins
        step(1'b1, 16'h1111, 4'd0, 1'b0);
        step(1'b1, 16'h2222, 4'd0, 1'b0);
        run_to_tick(1'b0);
        chk("pending_double", 16'(pending), 16'd0);
        frame_expect(1'b0, 32'hA4A4A4A4, 16'h7BDE);

        // Load exactly on the boundary cycle with nothing pending
        for (int i = 0; i < 4 * RDIV - 1; i++) step(1'b0, 16'd0, 4'd0, 1'b0);
        step(1'b1, 16'h3333, 4'd0, 1'b0);
        chk("pending_simul", 16'(pending), 16'd1);
        frame_expect(1'b0, 32'hA4A4A4A4, 16'h7BDE);
        frame_expect(1'b0, 32'hB0B0B0B0, 16'h7BDE);
        chk("pending_simul_clr", 16'(pending), 16'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 7) == 0), 16'($urandom), 4'($urandom),
                 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset mid-frame while a value is pending
        step(1'b1, 16'hBEEF, 4'b1010, 1'b0);
        step(1'b0, 16'd0, 4'd0, 1'b0);
        #2 RST_N = 1'b0;
        #1;
        chk("arst_sseg", 16'(sseg), 16'h00FF);
        chk("arst_en", 16'(DISP_EN), 16'h000F);
        chk("arst_pending", 16'(pending), 16'd0);
        chk("arst_tick", 16'(frame_tick), 16'd0);
        repeat (2) @(posedge CLOCK);
        @(negedge CLOCK);
        RST_N = 1'b1;
        model_reset();
        frame_expect(1'b0, 32'hC0C0C0C0, 16'h7BDE);
        frame_expect(1'b0, 32'hC0C0C0C0, 16'h7BDE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
